// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and the state types of the terminating slave FSMs.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WIDLE = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        RIDLE = 1'b0,
        RDATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi4_err_rd_chan.sv
// Read channel of the terminating slave: accepts one AR burst at a time and
// returns arlen+1 all-zero beats carrying the programmed response.
module axi4_err_rd_chan
    import axi4_pkg::*;
#(
    parameter int         ID_W   = 4,
    parameter int         DATA_W = 64,
    parameter logic [1:0] RESP   = RESP_DECERR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [7:0]        s_arlen,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [1:0]        s_rresp,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_rlast,
    output rd_state_e         state
);

    rd_state_e       state_q, state_n;
    logic [ID_W-1:0] id_q;
    logic [7:0]      len_q;
    logic [7:0]      cnt_q;
    logic            ar_hs;
    logic            r_hs;

    // All outputs are decoded from registers; enable holds arready low for
    // the first edge out of reset.
    assign s_arready = enable && (state_q == RIDLE);
    assign s_rvalid  = (state_q == RDATA);
    assign s_rid     = id_q;
    assign s_rresp   = RESP;
    assign s_rdata   = '0;
    assign s_rlast   = (state_q == RDATA) && (cnt_q == len_q);
    assign state     = state_q;

    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;

    // Next-state: leave idle on AR, return after the beat carrying rlast.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            RIDLE:   if (ar_hs) state_n = RDATA;
            RDATA:   if (r_hs && s_rlast) state_n = RIDLE;
            default: state_n = RIDLE;
        endcase
    end

    // State, latched request and beat counter. The 8-bit counter reaches 255
    // for arlen=255 before rlast; its wrap on that final beat is never seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RIDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            if (ar_hs) begin
                id_q  <= s_arid;
                len_q <= s_arlen;
                cnt_q <= '0;
            end else if (r_hs) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/axi4_err_slave.sv
// Terminating AXI4 slave for an unused port: every burst completes with RESP,
// echoing the request ID, so unmapped accesses fault instead of hanging.
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid and ready are both 1; a source holds valid and its payload stable
// until that edge, and this block never makes a ready depend on a valid.
module axi4_err_slave
    import axi4_pkg::*;
#(
    parameter int         ID_W   = 4,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64,
    parameter int         CNT_W  = 16,
    parameter logic [1:0] RESP   = RESP_DECERR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic              s_wlast,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [1:0]        s_rresp,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_rlast,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic              len_mismatch,
    output wr_state_e         wr_state,
    output rd_state_e         rd_state
);

    logic            run_q;
    wr_state_e       wr_state_q, wr_state_n;
    logic [ID_W-1:0] awid_q;
    logic [7:0]      awlen_q;
    logic [8:0]      wcnt_q;
    logic            aw_hs, w_hs, b_hs, ar_hs, r_last_hs;
    logic [1:0]      cnt_inc;
    logic [CNT_W:0]  cnt_sum;

    assign s_awready = run_q && (wr_state_q == WIDLE);
    assign s_wready  = (wr_state_q == WDATA);
    assign s_bvalid  = (wr_state_q == WRESP);
    assign s_bid     = awid_q;
    assign s_bresp   = RESP;
    assign wr_state  = wr_state_q;

    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign b_hs      = s_bvalid && s_bready;
    assign ar_hs     = s_arvalid && s_arready;
    assign r_last_hs = s_rvalid && s_rready && s_rlast;

    axi4_err_rd_chan #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .RESP   (RESP)
    ) u_rd_chan (
        .clock     (clock),
        .reset     (reset),
        .enable    (run_q),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_arid    (s_arid),
        .s_arlen   (s_arlen),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rid     (s_rid),
        .s_rresp   (s_rresp),
        .s_rdata   (s_rdata),
        .s_rlast   (s_rlast),
        .state     (rd_state)
    );

    // Readies stay low on the edge that applies reset and rise one cycle later.
    always_ff @(posedge clock) begin
        if (reset) run_q <= 1'b0;
        else       run_q <= 1'b1;
    end

    // Write next-state: AW, then W beats until wlast, then hold B until bready.
    always_comb begin
        wr_state_n = wr_state_q;
        unique case (wr_state_q)
            WIDLE:   if (aw_hs) wr_state_n = WDATA;
            WDATA:   if (w_hs && s_wlast) wr_state_n = WRESP;
            WRESP:   if (b_hs) wr_state_n = WIDLE;
            default: wr_state_n = WIDLE;
        endcase
    end

    // Write state, latched AW fields, W beat counter and sticky length flag.
    // wcnt_q counts beats before the current one, so wcnt_q == awlen means the
    // current wlast beat is beat awlen+1; it saturates to avoid false matches.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q   <= WIDLE;
            awid_q       <= '0;
            awlen_q      <= '0;
            wcnt_q       <= '0;
            len_mismatch <= 1'b0;
        end else begin
            wr_state_q <= wr_state_n;
            if (aw_hs) begin
                awid_q  <= s_awid;
                awlen_q <= s_awlen;
                wcnt_q  <= '0;
            end else if (w_hs && (wcnt_q != '1)) begin
                wcnt_q <= wcnt_q + 9'd1;
            end
            if (w_hs && s_wlast && (wcnt_q != {1'b0, awlen_q})) begin
                len_mismatch <= 1'b1;
            end
        end
    end

    // Completions this cycle (0..2) added with one guard bit for saturation.
    always_comb begin
        cnt_inc = {1'b0, b_hs} + {1'b0, r_last_hs};
        cnt_sum = {1'b0, err_cnt} + (CNT_W+1)'(cnt_inc);
    end

    // Saturating completed-burst counter.
    always_ff @(posedge clock) begin
        if (reset)              err_cnt <= '0;
        else if (cnt_sum[CNT_W]) err_cnt <= '1;
        else                    err_cnt <= cnt_sum[CNT_W-1:0];
    end

    // Last accepted request address; a simultaneous AW takes precedence over AR.
    always_ff @(posedge clock) begin
        if (reset)      err_addr <= '0;
        else if (aw_hs) err_addr <= s_awaddr;
        else if (ar_hs) err_addr <= s_araddr;
    end

endmodule
